seq_shift_add_mult: RTL and testbench

//  Clocked, parametrised N x N -> 2N multiplier using radix-2 shift-and-add over N iterations.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/cla_adder_n.sv | 47 ++++
 rtl/seq_shift_add_mult.sv | 114 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned MULT_DEFAULT_N = 8;
    localparam int unsigned ABS_W          = 64;

    // Magnitude of an n-bit operand held in the low bits of x; caller truncates to n bits.
    function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x,
                                               input int unsigned     n,
                                               input logic            sgn);
        if (sgn && x[n-1]) begin
            return ~x + ABS_W'(1);
        end
        return x;
    endfunction

endpackage

// File: rtl/cla_adder_n.sv
// W-bit carry-lookahead adder, purely combinational; carries resolved in 4-bit lookahead groups.
module cla_adder_n #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);

    localparam int GRP = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         grp_cin;
    logic         bit_cin;
    logic         gen;
    logic         prop;

    always_comb begin
        g       = a_i & b_i;
        p       = a_i ^ b_i;
        sum_o   = '0;
        grp_cin = cin_i;
        bit_cin = cin_i;
        gen     = 1'b0;
        prop    = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            if (i % GRP == 0) begin
                bit_cin = grp_cin;
            end
            sum_o[i] = p[i] ^ bit_cin;
            // Carry out of bit i, looked ahead from the group's carry-in.
            gen  = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= i - (i % GRP); j--) begin
                gen  = gen | (prop & g[j]);
                prop = prop & p[j];
            end
            bit_cin = gen | (prop & grp_cin);
            if (i % GRP == GRP - 1) begin
                grp_cin = bit_cin;
            end
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Clocked N x N -> 2N radix-2 shift-and-add multiplier with start/done handshake.
// Signed operands are multiplied as magnitudes and the sign is restored on completion.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned  N         = MULT_DEFAULT_N,
    parameter bit           SIGNED_EN = 1'b1,
    localparam int unsigned CNT_W     = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [N-1:0]     mcand_q,   mcand_d;
    logic [2*N:0]     acc_q,     acc_d;
    logic             neg_q,     neg_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [2*N-1:0]   product_q, product_d;

    logic             sgn;
    logic [N:0]       addend;
    logic [N:0]       hi_sum;

    // acc holds {hi (N+1 bits), lo (N bits)}; lo starts as the multiplier and shifts out LSB-first.
    assign addend = acc_q[0] ? {1'b0, mcand_q} : '0;

    cla_adder_n #(
        .W(N + 1)
    ) u_hi_adder (
        .a_i  (acc_q[2*N:N]),
        .b_i  (addend),
        .cin_i(1'b0),
        .sum_o(hi_sum)
    );

    always_comb begin
        sgn       = signed_mode & SIGNED_EN;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    mcand_d = N'(abs_n(ABS_W'(a), N, sgn));
                    acc_d   = {{(N + 1){1'b0}}, N'(abs_n(ABS_W'(b), N, sgn))};
                    neg_d   = sgn & (a[N-1] ^ b[N-1]);
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            StRun: begin
                acc_d = {hi_sum, acc_q[N-1:0]} >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d   = StDone;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = neg_q ? -acc_d[2*N-1:0] : acc_d[2*N-1:0];
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: cycle-level reference model for N=8 plus directed N=16 checks.
module tb_seq_shift_add_mult;

    localparam int unsigned N8  = 8;
    localparam int unsigned N16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    seq_shift_add_mult #(.N(N8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    seq_shift_add_mult #(.N(N16), .SIGNED_EN(1'b0)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                         input logic sm);
        longint px, py;
        if (sm) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return 16'(px * py);
    endfunction

    // Reference model for the N=8 instance: arithmetic result plus fixed-latency timing.
    int          m_remaining;
    logic [15:0] m_pending, m_product;
    logic        m_busy, m_done;

    task automatic m_reset();
        m_remaining = 0;
        m_pending   = '0;
        m_product   = '0;
        m_busy      = 1'b0;
        m_done      = 1'b0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                m_done = 1'b0;
                if (m_remaining > 0) begin
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_product = m_pending;
                        m_done    = 1'b1;
                        m_busy    = 1'b0;
                    end
                end else if (start8) begin
                    m_pending   = ref8(a8, b8, sm8);
                    m_remaining = N8;
                    m_busy      = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc busy", 64'(busy8), 64'(m_busy));
                check("cyc done", 64'(done8), 64'(m_done));
                check("cyc product", 64'(prod8), 64'(m_product));
            end
        end
    end

    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                           input logic [15:0] exp, input string name, input int poke,
                           input bit pin);
        int cnt;
        bit got;
        if (pin) check({name, " model"}, 64'(ref8(x, y, sm)), 64'(exp));
        @(posedge clk); #1;
        start8 = 1'b1; a8 = x; b8 = y; sm8 = sm;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < int'(N8) + 4) begin
            @(negedge clk);
            if (done8) begin
                got = 1'b1;
            end else begin
                cnt++;
                if (cnt == poke) begin
                    #2;
                    start8 = 1'b1; a8 = ~x; b8 = ~y;
                end else if (start8) begin
                    #2;
                    start8 = 1'b0;
                end
            end
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(cnt), 64'(N8));
        check({name, " product"}, 64'(prod8), 64'(exp));
    endtask

    task automatic run_op16(input logic [15:0] x, input logic [15:0] y, input logic sm,
                            input logic [31:0] exp, input string name);
        int cnt;
        bit got;
        @(posedge clk); #1;
        start16 = 1'b1; a16 = x; b16 = y; sm16 = sm;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < int'(N16) + 4) begin
            @(negedge clk);
            if (done16) got = 1'b1;
            else cnt++;
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(cnt), 64'(N16));
        check({name, " product"}, 64'(prod16), 64'(exp));
        @(negedge clk);
        check({name, " done one cycle"}, 64'(done16), 64'd0);
    endtask

    initial begin
        int  cnt;
        bit  got;
        logic [7:0] x, y;
        logic       s;

        @(negedge clk);
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset product", 64'(prod8), 64'd0);
        check("reset product16", 64'(prod16), 64'd0);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        run_op8(8'd13, 8'd11, 1'b0, 16'h008F, "u 13x11", -1, 1'b1);
        run_op8(8'd255, 8'd255, 1'b0, 16'hFE01, "u 255x255", -1, 1'b1);
        run_op8(8'd0, 8'd200, 1'b0, 16'h0000, "u 0x200", -1, 1'b1);
        run_op8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s -3x7", -1, 1'b1);
        run_op8(8'h80, 8'h80, 1'b1, 16'h4000, "s -128x-128", -1, 1'b1);
        run_op8(8'hFD, 8'h07, 1'b0, 16'h06EB, "u 253x7", -1, 1'b1);
        run_op8(8'd13, 8'd11, 1'b0, 16'h008F, "mid-run start", 3, 1'b0);

        // Back-to-back: start held high through DONE loads the second op directly.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd13; b8 = 8'd11; sm8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'hFD; b8 = 8'h07; sm8 = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < int'(N8) + 4) begin
            @(negedge clk);
            if (done8) got = 1'b1;
            else cnt++;
        end
        check("b2b first done", 64'(got), 64'd1);
        check("b2b first product", 64'(prod8), 64'h008F);
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        check("b2b no idle busy", 64'(busy8), 64'd1);
        cnt = 1;
        got = 1'b0;
        while (!got && cnt < int'(N8) + 4) begin
            @(negedge clk);
            if (done8) got = 1'b1;
            else cnt++;
        end
        check("b2b second done", 64'(got), 64'd1);
        check("b2b second latency", 64'(cnt), 64'(N8));
        check("b2b second product", 64'(prod8), 64'hFFEB);

        // Reset in the middle of RUN aborts with no done.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd3; sm8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        check("abort product", 64'(prod8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        got = 1'b0;
        repeat (2 * N8) begin
            @(negedge clk);
            if (done8) got = 1'b1;
        end
        check("abort no done", 64'(got), 64'd0);
        run_op8(8'd100, 8'd3, 1'b0, 16'h012C, "after reset", -1, 1'b1);

        for (int k = 0; k < 2000; k++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op8(x, y, s, ref8(x, y, s), "random", -1, 1'b0);
        end

        run_op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "n16 ffffxffff");
        run_op16(16'hFFFD, 16'h0007, 1'b1, 32'h0006FFEB, "n16 signed ignored");
        run_op16(16'h0080, 16'h0100, 1'b0, 32'h00008000, "n16 128x256");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
